// File: rtl/ts_pkt_scheduler_pkg.sv
// Shared types and constants for the TS packet scheduler.
package ts_pkt_scheduler_pkg;

  // FSM encodings; these values are visible on state_mon.
  typedef enum logic [1:0] {
    ST_SELECT = 2'd0,
    ST_GRANT  = 2'd1,
    ST_BUSY   = 2'd2,
    ST_RELOAD = 2'd3
  } state_t;

  // Plain TS packet length and length with a 4-byte timestamp prefix.
  localparam int TS_PKT_LEN        = 188;
  localparam int TS_PKT_LEN_TAGGED = 192;

  localparam int WEIGHT_W = 4;
  localparam int SRC_W    = 2;
  localparam int NUM_SRC  = 4;
  localparam int CNT_W    = 16;

  // Saturating increment for the idle counter and the watchdog.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ts_pkt_scheduler_if.sv
// Buffer-flag / grant handshake bundle between scheduler and source switch.
interface ts_pkt_scheduler_if;
  import ts_pkt_scheduler_pkg::*;

  logic [NUM_SRC-1:0]          PKT_READY;
  logic [NUM_SRC*WEIGHT_W-1:0] WEIGHT_BUS;
  logic                        GRANT_VALID;
  logic [SRC_W-1:0]            GRANT_SRC;
  logic                        GRANT_NULL;
  logic                        GRANT_ACK;
  logic                        PKT_DONE;
  logic                        ERR_TIMEOUT;
  logic [1:0]                  state_mon;

  // Scheduler side.
  modport master (
    input  PKT_READY, WEIGHT_BUS, GRANT_ACK, PKT_DONE,
    output GRANT_VALID, GRANT_SRC, GRANT_NULL, ERR_TIMEOUT, state_mon
  );

  // Switch / buffer side.
  modport slave (
    output PKT_READY, WEIGHT_BUS, GRANT_ACK, PKT_DONE,
    input  GRANT_VALID, GRANT_SRC, GRANT_NULL, ERR_TIMEOUT, state_mon
  );

endinterface

// File: rtl/ts_pkt_scheduler_wrr_pick.sv
// Rotating-priority picker: first eligible source after 'last', wrapping 3 to 0.
module wrr_pick
  import ts_pkt_scheduler_pkg::*;
(
  input  logic [NUM_SRC-1:0] eligible,
  input  logic [SRC_W-1:0]   last,
  output logic               found,
  output logic [SRC_W-1:0]   idx
);

  logic [SRC_W-1:0] cand;

  // Scan last+1, last+2, ... last+4; the 2-bit add provides the wrap.
  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand = last + SRC_W'(i);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ts_pkt_scheduler.sv
// Weighted round-robin scheduler granting one TS packet at a time to the switch.
module ts_pkt_scheduler
  import ts_pkt_scheduler_pkg::*;
#(
  parameter int unsigned NULL_TIMEOUT = 1024,
  parameter int unsigned DONE_TIMEOUT = 512
) (
  input logic                 SYS_CLK,
  input logic                 RST,
  ts_pkt_scheduler_if.master  bus
);

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(NULL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(DONE_TIMEOUT - 1);

  state_t                state, state_nxt;
  logic [WEIGHT_W-1:0]   credit     [NUM_SRC];
  logic [WEIGHT_W-1:0]   credit_nxt [NUM_SRC];
  logic [WEIGHT_W-1:0]   weight     [NUM_SRC];
  logic [SRC_W-1:0]      last, last_nxt;
  logic [SRC_W-1:0]      src_r, src_nxt;
  logic                  null_r, null_nxt;
  logic                  err_r, err_nxt;
  logic                  grant_valid_r;
  logic [CNT_W-1:0]      idle_cnt, idle_nxt;
  logic [CNT_W-1:0]      wd_cnt, wd_nxt;
  logic [NUM_SRC-1:0]    eligible;
  logic                  reload_need;
  logic                  pick_found;
  logic [SRC_W-1:0]      pick_idx;

  // Per-source weight slice, eligibility and "reload would help" flag.
  always_comb begin
    reload_need = 1'b0;
    for (int n = 0; n < NUM_SRC; n++) begin
      weight[n]   = bus.WEIGHT_BUS[n*WEIGHT_W +: WEIGHT_W];
      eligible[n] = bus.PKT_READY[n] && (credit[n] != '0);
      if (bus.PKT_READY[n] && (weight[n] != '0)) reload_need = 1'b1;
    end
  end

  wrr_pick u_pick (
    .eligible (eligible),
    .last     (last),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  // Next-state and next-register logic for the scheduler FSM.
  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    last_nxt   = last;
    src_nxt    = src_r;
    null_nxt   = null_r;
    err_nxt    = 1'b0;
    idle_nxt   = sat_inc(idle_cnt);
    wd_nxt     = sat_inc(wd_cnt);

    unique case (state)
      ST_SELECT: begin
        if (pick_found) begin
          src_nxt   = pick_idx;
          state_nxt = ST_GRANT;
        end else if (reload_need) begin
          state_nxt = ST_RELOAD;
        end else if (idle_cnt == IDLE_LAST) begin
          null_nxt  = 1'b1;
          src_nxt   = '0;
          state_nxt = ST_GRANT;
        end
      end
      ST_RELOAD: begin
        for (int n = 0; n < NUM_SRC; n++) credit_nxt[n] = weight[n];
        state_nxt = ST_SELECT;
      end
      ST_GRANT: begin
        if (bus.GRANT_ACK) begin
          if (!null_r) begin
            if (credit[src_r] != '0) credit_nxt[src_r] = credit[src_r] - WEIGHT_W'(1);
            last_nxt = src_r;
          end
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A completion on the expiry edge wins over the abort.
        if (bus.PKT_DONE) begin
          null_nxt  = 1'b0;
          state_nxt = ST_SELECT;
        end else if (wd_cnt == WD_LAST) begin
          err_nxt   = 1'b1;
          null_nxt  = 1'b0;
          state_nxt = ST_SELECT;
        end
      end
      default: state_nxt = ST_SELECT;
    endcase

    // Both counters restart on every state entry.
    if (state_nxt != state) begin
      idle_nxt = '0;
      wd_nxt   = '0;
    end
  end

  // State and output registers; credits are only four nibbles, so they reset with the rest.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      state         <= ST_SELECT;
      for (int n = 0; n < NUM_SRC; n++) credit[n] <= '0;
      last          <= SRC_W'(NUM_SRC - 1);
      src_r         <= '0;
      null_r        <= 1'b0;
      err_r         <= 1'b0;
      grant_valid_r <= 1'b0;
      idle_cnt      <= '0;
      wd_cnt        <= '0;
    end else begin
      state         <= state_nxt;
      credit        <= credit_nxt;
      last          <= last_nxt;
      src_r         <= src_nxt;
      null_r        <= null_nxt;
      err_r         <= err_nxt;
      grant_valid_r <= (state_nxt == ST_GRANT);
      idle_cnt      <= idle_nxt;
      wd_cnt        <= wd_nxt;
    end
  end

  assign bus.GRANT_VALID = grant_valid_r;
  assign bus.GRANT_SRC   = src_r;
  assign bus.GRANT_NULL  = null_r;
  assign bus.ERR_TIMEOUT = err_r;
  assign bus.state_mon   = state;

endmodule

// File: tb/tb_ts_pkt_scheduler.sv
// Directed self-checking bench for ts_pkt_scheduler.
module tb_ts_pkt_scheduler;
  import ts_pkt_scheduler_pkg::*;

  logic SYS_CLK = 1'b0;
  logic RST     = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 SYS_CLK = ~SYS_CLK;

  ts_pkt_scheduler_if bus ();

  ts_pkt_scheduler #(.NULL_TIMEOUT(1024), .DONE_TIMEOUT(512)) dut (
    .SYS_CLK (SYS_CLK),
    .RST     (RST),
    .bus     (bus)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge SYS_CLK);
  endtask

  task automatic do_reset(input logic [3:0] ready, input logic [15:0] weights);
    RST            = 1'b0;
    bus.GRANT_ACK  = 1'b0;
    bus.PKT_DONE   = 1'b0;
    bus.PKT_READY  = ready;
    bus.WEIGHT_BUS = weights;
    tick();
    tick();
    RST = 1'b1;
  endtask

  // Waits (bounded) for GRANT_VALID and checks latency in cycles, source and null flag.
  task automatic wait_grant(input string tag, input int exp_src, input int exp_null, input int exp_lat);
    int cnt = 0;
    while (!bus.GRANT_VALID && cnt < 2000) begin
      tick();
      cnt++;
    end
    check({tag, "_lat"}, cnt, exp_lat);
    check({tag, "_src"}, bus.GRANT_SRC, exp_src);
    check({tag, "_null"}, bus.GRANT_NULL, exp_null);
  endtask

  // Accepts the pending grant and completes it done_delay cycles after the ACK.
  task automatic serve(input string tag, input int done_delay);
    bus.GRANT_ACK = 1'b1;
    tick();
    bus.GRANT_ACK = 1'b0;
    check({tag, "_busy"}, bus.state_mon, 2);
    repeat (done_delay - 1) tick();
    bus.PKT_DONE = 1'b1;
    tick();
    bus.PKT_DONE = 1'b0;
    check({tag, "_sel"}, bus.state_mon, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int seq1 [6] = '{0, 1, 2, 3, 0, 1};
    int lat1 [6] = '{3, 1, 1, 1, 3, 1};
    int seq2 [8] = '{0, 1, 0, 0, 1, 0, 0, 0};
    int lat2 [8] = '{3, 1, 1, 1, 3, 1, 1, 1};
    int cnt;

    // Reset values.
    do_reset(4'hF, 16'h1111);
    RST = 1'b0;
    tick();
    check("rst_valid", bus.GRANT_VALID, 0);
    check("rst_src",   bus.GRANT_SRC,   0);
    check("rst_null",  bus.GRANT_NULL,  0);
    check("rst_err",   bus.ERR_TIMEOUT, 0);
    check("rst_state", bus.state_mon,   0);

    // Weights 1/1/1/1, all ready: 0,1,2,3 then a reload, then 0,1.
    RST = 1'b1;
    tick();
    check("t1_reload_state", bus.state_mon, 3);
    tick();
    check("t1_select_state", bus.state_mon, 0);
    wait_grant("t1_g0", seq1[0], 0, 1);
    serve("t1_s0", 200);
    for (int i = 1; i < 6; i++) begin
      wait_grant($sformatf("t1_g%0d", i), seq1[i], 0, lat1[i]);
      serve($sformatf("t1_s%0d", i), 200);
    end

    // Weights 3/1/0/0 with source 2 ready but disabled.
    do_reset(4'b0111, 16'h0013);
    for (int i = 0; i < 8; i++) begin
      wait_grant($sformatf("t2_g%0d", i), seq2[i], 0, lat2[i]);
      serve($sformatf("t2_s%0d", i), 20);
    end

    // Nothing ready: null grant after NULL_TIMEOUT cycles, credits untouched.
    do_reset(4'h0, 16'h1111);
    wait_grant("t3_null", 0, 1, 1024);
    bus.GRANT_ACK = 1'b1;
    tick();
    bus.GRANT_ACK = 1'b0;
    check("t3_null_busy", bus.GRANT_NULL, 1);
    bus.PKT_READY = 4'hF;
    repeat (19) tick();
    bus.PKT_DONE = 1'b1;
    tick();
    bus.PKT_DONE = 1'b0;
    check("t3_null_clear", bus.GRANT_NULL, 0);
    wait_grant("t3_after_null", 0, 0, 3);

    // Withheld PKT_DONE: watchdog abort 512 cycles after the ACK, then source 1.
    bus.GRANT_ACK = 1'b1;
    tick();
    bus.GRANT_ACK = 1'b0;
    cnt = 0;
    while (!bus.ERR_TIMEOUT && cnt < 600) begin
      tick();
      cnt++;
    end
    check("t4_wd_lat", cnt, 512);
    check("t4_wd_state", bus.state_mon, 0);
    wait_grant("t4_next", 1, 0, 1);
    check("t4_err_pulse", bus.ERR_TIMEOUT, 0);
    bus.PKT_READY = 4'h0;
    serve("t4_s", 20);

    // Stray DONE and ACK in SELECT, then ACK present as GRANT_VALID rises.
    bus.PKT_DONE = 1'b1;
    tick();
    bus.PKT_DONE = 1'b0;
    check("t5_stray_done", bus.state_mon, 0);
    bus.GRANT_ACK = 1'b1;
    tick();
    bus.GRANT_ACK = 1'b0;
    check("t5_stray_ack", bus.state_mon, 0);
    bus.PKT_READY = 4'hF;
    bus.GRANT_ACK = 1'b1;
    tick();
    check("t5_one_valid", bus.GRANT_VALID, 1);
    check("t5_one_src", bus.GRANT_SRC, 2);
    tick();
    bus.GRANT_ACK = 1'b0;
    check("t5_one_drop", bus.GRANT_VALID, 0);
    check("t5_one_busy", bus.state_mon, 2);

    // Reset while BUSY on source 2: everything clears, source 0 scanned first.
    RST = 1'b0;
    tick();
    check("t6_valid", bus.GRANT_VALID, 0);
    check("t6_src",   bus.GRANT_SRC,   0);
    check("t6_state", bus.state_mon,   0);
    RST = 1'b1;
    wait_grant("t6_after", 0, 0, 3);
    serve("t6_s", 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
